// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control FSM for the MIPS datapath.
// Inputs:  clk, reset (async, active-high), instr (IR), equal (ALU flag),
//          mem_ready (DM handshake).
// Outputs: ir_write, pc_write, pc_op, reg_dst, alu_src, alu_op, ext_op,
//          mem_read, mem_write, reg_write, mem_to_reg, state, retired.
module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             equal,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_op,
  output logic [1:0]       reg_dst,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [5:0] op, fn;
  assign op = instr[31:26];
  assign fn = instr[5:0];

  // Only opcode and funct take part in control decode.
  logic unused_instr;
  assign unused_instr = ^instr[25:6];

  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal, is_alu;

  assign is_r    = (op == 6'b000000);
  assign is_addu = is_r && (fn == 6'b100001);
  assign is_subu = is_r && (fn == 6'b100011);
  assign is_jr   = is_r && (fn == 6'b001000);
  assign is_ori  = (op == 6'b001101);
  assign is_lui  = (op == 6'b001111);
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_beq  = (op == 6'b000100);
  assign is_j    = (op == 6'b000010);
  assign is_jal  = (op == 6'b000011);
  assign is_alu  = is_addu | is_subu | is_ori | is_lui;

  // Raw (pre-reset-gating) control values.
  logic       irw_r, pcw_r, rw_r, mr_r, mw_r, src_r, sel_en;
  logic [1:0] pco_r, rd_r, ext_r, m2r_r;
  logic [2:0] aop_r;

  // EXE selects, held through MEM/WB of the same instruction.
  logic       src_x;
  logic [2:0] aop_x;
  logic [1:0] ext_x;

  always_comb begin
    src_x = is_ori | is_lw | is_sw;
    aop_x = 3'b000;
    if (is_subu | is_beq)
      aop_x = 3'b001;
    else if (is_ori)
      aop_x = 3'b010;
    ext_x = 2'b00;
    if (is_lw | is_sw)
      ext_x = 2'b01;
    else if (is_lui)
      ext_x = 2'b10;
  end

  always_comb begin
    state_d = S_FETCH;
    irw_r   = 1'b0;
    pcw_r   = 1'b0;
    rw_r    = 1'b0;
    mr_r    = 1'b0;
    mw_r    = 1'b0;
    sel_en  = 1'b0;
    rd_r    = 2'b00;
    m2r_r   = 2'b00;
    case (state_q)
      S_FETCH: begin
        irw_r   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_alu | is_lw | is_sw | is_beq)
          state_d = S_EXE;
        else if (is_jal)
          state_d = S_WB;
        else
          pcw_r = 1'b1;
      end
      S_EXE: begin
        sel_en = 1'b1;
        if (is_alu)
          state_d = S_WB;
        else if (is_lw | is_sw)
          state_d = S_MEM;
        else
          pcw_r = 1'b1;
      end
      S_MEM: begin
        sel_en = 1'b1;
        mr_r   = is_lw;
        mw_r   = is_sw;
        // Hold the request until the DM accepts it.
        if ((is_lw | is_sw) && !mem_ready)
          state_d = S_MEM;
        else if (is_lw)
          state_d = S_WB;
        else
          pcw_r = 1'b1;
      end
      S_WB: begin
        sel_en = 1'b1;
        rw_r   = 1'b1;
        pcw_r  = 1'b1;
        if (is_addu | is_subu) begin
          rd_r  = 2'b01;
          m2r_r = 2'b01;
        end else if (is_ori) begin
          m2r_r = 2'b01;
        end else if (is_lui) begin
          m2r_r = 2'b10;
        end else if (is_jal) begin
          rd_r  = 2'b10;
          m2r_r = 2'b11;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    src_r = sel_en ? src_x : 1'b0;
    aop_r = sel_en ? aop_x : 3'b000;
    ext_r = sel_en ? ext_x : 2'b00;
    pco_r = 2'b00;
    if (pcw_r) begin
      if (is_beq && equal)
        pco_r = 2'b01;
      else if (is_j | is_jal)
        pco_r = 2'b10;
      else if (is_jr)
        pco_r = 2'b11;
    end
  end

  // Reset overrides every output immediately, without waiting for a clock.
  assign ir_write   = reset ? 1'b0   : irw_r;
  assign pc_write   = reset ? 1'b0   : pcw_r;
  assign pc_op      = reset ? 2'b00  : pco_r;
  assign reg_dst    = reset ? 2'b00  : rd_r;
  assign alu_src    = reset ? 1'b0   : src_r;
  assign alu_op     = reset ? 3'b000 : aop_r;
  assign ext_op     = reset ? 2'b00  : ext_r;
  assign mem_read   = reset ? 1'b0   : mr_r;
  assign mem_write  = reset ? 1'b0   : mw_r;
  assign reg_write  = reset ? 1'b0   : rw_r;
  assign mem_to_reg = reset ? 2'b00  : m2r_r;
  assign state      = state_q;
  assign retired    = retired_q;

  assign retired_d = pcw_r ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed bench for mc_controller.
// A second instance with a 2-bit counter exercises counter wrap.
module tb_mc_controller;

  logic        clk, reset, equal, mem_ready;
  logic [31:0] instr;
  logic        ir_write, pc_write, alu_src;
  logic        mem_read, mem_write, reg_write;
  logic [1:0]  pc_op, reg_dst, ext_op, mem_to_reg;
  logic [2:0]  alu_op, state;
  logic [31:0] retired;
  logic [1:0]  ret2;
  logic [19:0] unused_w2;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = 0;

  mc_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .equal(equal), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write),
    .pc_op(pc_op), .reg_dst(reg_dst),
    .alu_src(alu_src), .alu_op(alu_op),
    .ext_op(ext_op), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .state(state),
    .retired(retired)
  );

  mc_controller #(.CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .instr(instr),
    .equal(equal), .mem_ready(mem_ready),
    .ir_write(unused_w2[0]), .pc_write(unused_w2[1]),
    .pc_op(unused_w2[3:2]), .reg_dst(unused_w2[5:4]),
    .alu_src(unused_w2[6]), .alu_op(unused_w2[9:7]),
    .ext_op(unused_w2[11:10]), .mem_read(unused_w2[12]),
    .mem_write(unused_w2[13]), .reg_write(unused_w2[14]),
    .mem_to_reg(unused_w2[16:15]), .state(unused_w2[19:17]),
    .retired(ret2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] mk_ctl(int st, bit irw, bit pcw,
                                        int pco, bit rw, bit mr, bit mw);
    return {st[2:0], irw, pcw, pco[1:0], rw, mr, mw};
  endfunction

  function automatic logic [9:0] mk_sel(int rd, bit as, int ao,
                                        int eo, int m2r);
    return {rd[1:0], as, ao[2:0], eo[1:0], m2r[1:0]};
  endfunction

  task automatic chk_cyc(input string t, input logic [9:0] c,
                         input logic [9:0] s);
    #1;
    check({t, " ctl"}, 32'({state, ir_write, pc_write, pc_op,
                            reg_write, mem_read, mem_write}), 32'(c));
    check({t, " sel"}, 32'({reg_dst, alu_src, alu_op,
                            ext_op, mem_to_reg}), 32'(s));
    check({t, " ret"}, retired, exp_ret);
    check({t, " ret2"}, 32'(ret2), 32'(exp_ret[1:0]));
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_alu(input string t, input logic [31:0] ins,
                         input logic [9:0] se, input logic [9:0] sw);
    instr = ins;
    chk_cyc({t, " F"}, mk_ctl(0, 1, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc({t, " D"}, mk_ctl(1, 0, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc({t, " E"}, mk_ctl(2, 0, 0, 0, 0, 0, 0), se);
    step();
    chk_cyc({t, " W"}, mk_ctl(4, 0, 1, 0, 1, 0, 0), sw);
    step();
    exp_ret++;
  endtask

  task automatic run_beq(input string t, input bit eq);
    instr = 32'h10850003;
    equal = eq;
    chk_cyc({t, " F"}, mk_ctl(0, 1, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc({t, " D"}, mk_ctl(1, 0, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc({t, " E"}, mk_ctl(2, 0, 1, eq ? 1 : 0, 0, 0, 0),
            mk_sel(0, 0, 1, 0, 0));
    step();
    exp_ret++;
  endtask

  initial begin
    reset     = 1'b1;
    instr     = 32'h0;
    equal     = 1'b0;
    mem_ready = 1'b1;
    #11;
    chk_cyc("reset", mk_ctl(0, 0, 0, 0, 0, 0, 0), 10'd0);
    reset = 1'b0;

    run_alu("addu", 32'h00851021, mk_sel(0, 0, 0, 0, 0),
            mk_sel(1, 0, 0, 0, 1));

    instr     = 32'h8C820004;
    mem_ready = 1'b0;
    chk_cyc("lw F", mk_ctl(0, 1, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc("lw D", mk_ctl(1, 0, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc("lw E", mk_ctl(2, 0, 0, 0, 0, 0, 0), mk_sel(0, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk_cyc("lw Mwait", mk_ctl(3, 0, 0, 0, 0, 1, 0),
              mk_sel(0, 1, 0, 1, 0));
    end
    step();
    mem_ready = 1'b1;
    chk_cyc("lw Mrdy", mk_ctl(3, 0, 0, 0, 0, 1, 0), mk_sel(0, 1, 0, 1, 0));
    step();
    chk_cyc("lw W", mk_ctl(4, 0, 1, 0, 1, 0, 0), mk_sel(0, 1, 0, 1, 0));
    step();
    exp_ret++;

    run_beq("beq eq1", 1'b1);
    run_beq("beq eq0", 1'b0);
    check("wrap2", 32'(ret2), 32'd0);
    equal = 1'b0;

    instr = 32'h0C000C00;
    chk_cyc("jal F", mk_ctl(0, 1, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc("jal D", mk_ctl(1, 0, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc("jal W", mk_ctl(4, 0, 1, 2, 1, 0, 0), mk_sel(2, 0, 0, 0, 3));
    step();
    exp_ret++;

    instr = 32'h03E00008;
    chk_cyc("jr F", mk_ctl(0, 1, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc("jr D", mk_ctl(1, 0, 1, 3, 0, 0, 0), 10'd0);
    step();
    exp_ret++;

    instr = 32'hFC000000;
    chk_cyc("nop F", mk_ctl(0, 1, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc("nop D", mk_ctl(1, 0, 1, 0, 0, 0, 0), 10'd0);
    step();
    exp_ret++;

    run_alu("ori", 32'h34A500FF, mk_sel(0, 1, 2, 0, 0),
            mk_sel(0, 1, 2, 0, 1));
    run_alu("lui", 32'h3C051234, mk_sel(0, 0, 0, 2, 0),
            mk_sel(0, 0, 0, 2, 2));
    run_alu("subu", 32'h00851023, mk_sel(0, 0, 1, 0, 0),
            mk_sel(1, 0, 1, 0, 1));

    instr = 32'hAC820004;
    chk_cyc("sw F", mk_ctl(0, 1, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc("sw D", mk_ctl(1, 0, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc("sw E", mk_ctl(2, 0, 0, 0, 0, 0, 0), mk_sel(0, 1, 0, 1, 0));
    step();
    chk_cyc("sw M", mk_ctl(3, 0, 1, 0, 0, 0, 1), mk_sel(0, 1, 0, 1, 0));
    step();
    exp_ret++;

    mem_ready = 1'b0;
    chk_cyc("swr F", mk_ctl(0, 1, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc("swr D", mk_ctl(1, 0, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc("swr E", mk_ctl(2, 0, 0, 0, 0, 0, 0), mk_sel(0, 1, 0, 1, 0));
    step();
    chk_cyc("swr M0", mk_ctl(3, 0, 0, 0, 0, 0, 1), mk_sel(0, 1, 0, 1, 0));
    step();
    chk_cyc("swr M1", mk_ctl(3, 0, 0, 0, 0, 0, 1), mk_sel(0, 1, 0, 1, 0));
    reset   = 1'b1;
    exp_ret = 0;
    chk_cyc("rst mid", mk_ctl(0, 0, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc("rst hold", mk_ctl(0, 0, 0, 0, 0, 0, 0), 10'd0);
    reset     = 1'b0;
    mem_ready = 1'b1;
    instr     = 32'h0;
    chk_cyc("rel F", mk_ctl(0, 1, 0, 0, 0, 0, 0), 10'd0);
    step();
    chk_cyc("rel D", mk_ctl(1, 0, 1, 0, 0, 0, 0), 10'd0);
    step();
    exp_ret++;
    chk_cyc("rel F2", mk_ctl(0, 1, 0, 0, 0, 0, 0), 10'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
